// File: rtl/ad_seq_ctrl.sv
// Sequences a WIDTH-bit add over an external 2-bit slice, LSB pair first; done one cycle after N=WIDTH/2 RUN edges.
// start is ignored while busy (no queuing); `AD_SEQ_SUB_EN adds op_sub for a - b.
module ad_seq_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef AD_SEQ_SUB_EN
    input  logic             op_sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic [1:0]       slice_a,
    output logic [1:0]       slice_b,
    output logic             slice_ci,
    input  logic [1:0]       slice_s,
    input  logic             slice_co
);

    localparam int N  = WIDTH / 2;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_carry;
    logic [IW-1:0]    r_idx;

    logic             w_accept;
    logic             w_last;
    logic [WIDTH-1:0] w_b_load;
    logic             w_carry_load;
    logic [WIDTH-1:0] w_acc_nxt;

`ifdef AD_SEQ_SUB_EN
    // Subtraction as a + ~b + 1; the incoming carry is deliberately dropped.
    assign w_b_load     = op_sub ? ~b : b;
    assign w_carry_load = op_sub ? 1'b1 : cin;
`else
    assign w_b_load     = b;
    assign w_carry_load = cin;
`endif

    assign w_last    = (r_idx == LAST_IDX);
    assign w_acc_nxt = (r_acc >> 2) | (WIDTH'(slice_s) << (WIDTH - 2));
    assign sum       = r_sum;
    assign cout      = r_cout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Slice inputs are forced to zero outside RUN so nothing loops through the slice.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        slice_a     = 2'b00;
        slice_b     = 2'b00;
        slice_ci    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                busy     = 1'b1;
                slice_a  = r_a_sh[1:0];
                slice_b  = r_b_sh[1:0];
                slice_ci = r_carry;
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done = 1'b1;
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_RUN;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_acc   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_carry <= 1'b0;
            r_idx   <= '0;
        end else if (w_accept) begin
            r_a_sh  <= a;
            r_b_sh  <= w_b_load;
            r_carry <= w_carry_load;
            r_idx   <= '0;
        end else if (r_state == S_RUN) begin
            r_a_sh  <= r_a_sh >> 2;
            r_b_sh  <= r_b_sh >> 2;
            r_acc   <= w_acc_nxt;
            r_carry <= slice_co;
            if (w_last) begin
                r_sum  <= w_acc_nxt;
                r_cout <= slice_co;
            end else begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ad_seq_ctrl.sv
// Directed bench for ad_seq_ctrl: WIDTH=8 instance plus a WIDTH=2 instance, each with a behavioural 2-bit slice.
module tb_ad_seq_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start;
    logic [7:0] a, b;
    logic       cin;
    logic       busy, done, cout;
    logic [7:0] sum;
    logic [1:0] slice_a, slice_b, slice_s;
    logic       slice_ci, slice_co;
`ifdef AD_SEQ_SUB_EN
    logic       op_sub;
`endif

    logic       start2;
    logic [1:0] a2, b2;
    logic       cin2;
    logic       busy2, done2, cout2;
    logic [1:0] sum2;
    logic [1:0] slice_a2, slice_b2, slice_s2;
    logic       slice_ci2, slice_co2;

    int checks   = 0;
    int failures = 0;

    assign {slice_co, slice_s}   = {1'b0, slice_a} + {1'b0, slice_b} + {2'b00, slice_ci};
    assign {slice_co2, slice_s2} = {1'b0, slice_a2} + {1'b0, slice_b2} + {2'b00, slice_ci2};

    ad_seq_ctrl #(.WIDTH(8)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .cin      (cin),
`ifdef AD_SEQ_SUB_EN
        .op_sub   (op_sub),
`endif
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .cout     (cout),
        .slice_a  (slice_a),
        .slice_b  (slice_b),
        .slice_ci (slice_ci),
        .slice_s  (slice_s),
        .slice_co (slice_co)
    );

    ad_seq_ctrl #(.WIDTH(2)) u_dut2 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start2),
        .a        (a2),
        .b        (b2),
        .cin      (cin2),
`ifdef AD_SEQ_SUB_EN
        .op_sub   (1'b0),
`endif
        .busy     (busy2),
        .done     (done2),
        .sum      (sum2),
        .cout     (cout2),
        .slice_a  (slice_a2),
        .slice_b  (slice_b2),
        .slice_ci (slice_ci2),
        .slice_s  (slice_s2),
        .slice_co (slice_co2)
    );

    // Pulses start for one cycle from a negedge; returns at the negedge where done is seen (or the bound).
    task automatic run_op(input logic [7:0] ia, input logic [7:0] ib, input logic ic, output int lat);
        a = ia; b = ib; cin = ic; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (done !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0; a = 8'h00; b = 8'h00; cin = 1'b0;
        start2 = 1'b0; a2 = 2'd0; b2 = 2'd0; cin2 = 1'b0;
`ifdef AD_SEQ_SUB_EN
        op_sub = 1'b0;
`endif
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (sum !== 8'h00) begin failures++; $display("FAIL reset_sum got=%h exp=00", sum); end
        checks++; if (cout !== 1'b0) begin failures++; $display("FAIL reset_cout got=%b exp=0", cout); end
        checks++; if ({slice_a, slice_b, slice_ci} !== 5'b0) begin
            failures++; $display("FAIL reset_slice got=%b exp=00000", {slice_a, slice_b, slice_ci});
        end
        checks++; if ({busy2, done2, sum2, cout2} !== 5'b0) begin
            failures++; $display("FAIL reset_w2 got=%b exp=00000", {busy2, done2, sum2, cout2});
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin
            failures++; $display("FAIL reset_idle busy=%b done=%b exp=0,0", busy, done);
        end
    endtask

    task automatic test_basic();
        logic [1:0] exp_a [4] = '{2'd2, 2'd2, 2'd1, 2'd1};
        logic [1:0] exp_b [4] = '{2'd3, 2'd0, 2'd3, 2'd0};
        logic       exp_c [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        int k, n;
        a = 8'h5A; b = 8'h33; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 1; n = 0;
        while (done !== 1'b1 && k < 20) begin
            if (busy === 1'b1) begin
                if (n < 4) begin
                    checks++;
                    if (slice_a !== exp_a[n] || slice_b !== exp_b[n] || slice_ci !== exp_c[n]) begin
                        failures++;
                        $display("FAIL basic_slice%0d got=(%0d,%0d,%0d) exp=(%0d,%0d,%0d)", n,
                                 slice_a, slice_b, slice_ci, exp_a[n], exp_b[n], exp_c[n]);
                    end
                end
                n++;
            end
            @(negedge clk);
            k++;
        end
        checks++; if (n !== 4) begin failures++; $display("FAIL basic_busy_cycles got=%0d exp=4", n); end
        checks++; if (k !== 5) begin failures++; $display("FAIL basic_latency got=%0d exp=5", k); end
        checks++; if (sum !== 8'h8D) begin failures++; $display("FAIL basic_sum got=%h exp=8d", sum); end
        checks++; if (cout !== 1'b0) begin failures++; $display("FAIL basic_cout got=%b exp=0", cout); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL basic_done_pulse got=%b exp=0", done); end
        checks++; if (sum !== 8'h8D || cout !== 1'b0) begin
            failures++; $display("FAIL basic_hold got=%h/%b exp=8d/0", sum, cout);
        end
    endtask

    task automatic test_carry();
        logic [7:0] ta [3] = '{8'hFF, 8'hFF, 8'hFF};
        logic [7:0] tb [3] = '{8'h01, 8'h01, 8'hFF};
        logic       tc [3] = '{1'b0, 1'b1, 1'b1};
        logic [7:0] es [3] = '{8'h00, 8'h01, 8'hFF};
        logic       ec [3] = '{1'b1, 1'b1, 1'b1};
        int lat;
        for (int i = 0; i < 3; i++) begin
            run_op(ta[i], tb[i], tc[i], lat);
            checks++; if (lat !== 5) begin failures++; $display("FAIL carry%0d_latency got=%0d exp=5", i, lat); end
            checks++; if (sum !== es[i] || cout !== ec[i]) begin
                failures++; $display("FAIL carry%0d_result got=%h/%b exp=%h/%b", i, sum, cout, es[i], ec[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] ta [4] = '{8'h12, 8'h80, 8'hF0, 8'hAA};
        logic [7:0] tb [4] = '{8'h34, 8'h80, 8'h0F, 8'h55};
        logic       tc [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [7:0] es [4] = '{8'h46, 8'h01, 8'hFF, 8'h00};
        logic       ec [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic       exp_done;
        for (int c = 0; c <= 20; c++) begin
            if (c > 0) begin
                exp_done = (c % 5 == 0);
                checks++;
                if (done !== exp_done) begin
                    failures++; $display("FAIL b2b_done_c%0d got=%b exp=%b", c, done, exp_done);
                end
                if (exp_done) begin
                    checks++;
                    if (sum !== es[c/5-1] || cout !== ec[c/5-1]) begin
                        failures++;
                        $display("FAIL b2b_result%0d got=%h/%b exp=%h/%b", c/5-1, sum, cout, es[c/5-1], ec[c/5-1]);
                    end
                end
            end
            if (c < 20) begin
                start = 1'b1;
                if (c % 5 == 0) begin
                    a = ta[c/5]; b = tb[c/5]; cin = tc[c/5];
                end else begin
                    a = 8'(c * 37); b = 8'(c * 11 + 5); cin = c[0];
                end
                @(negedge clk);
            end
        end
        start = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_ignore_start();
        int k, cnt, dk;
        logic [7:0] s;
        logic       co;
        cnt = 0; dk = 0; s = 8'h00; co = 1'b0;
        a = 8'h21; b = 8'h43; cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a = 8'hFF; b = 8'hFF; cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 3;
        while (k <= 15) begin
            if (done === 1'b1) begin
                cnt++;
                if (cnt == 1) begin dk = k; s = sum; co = cout; end
            end
            @(negedge clk);
            k++;
        end
        checks++; if (cnt !== 1) begin failures++; $display("FAIL ignore_done_count got=%0d exp=1", cnt); end
        checks++; if (dk !== 5) begin failures++; $display("FAIL ignore_latency got=%0d exp=5", dk); end
        checks++; if (s !== 8'h65 || co !== 1'b0) begin
            failures++; $display("FAIL ignore_result got=%h/%b exp=65/0", s, co);
        end
    endtask

    task automatic test_reset_mid_run();
        int cnt, lat;
        cnt = 0;
        a = 8'h5A; b = 8'h33; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL midrst_pre_busy got=%b exp=1", busy); end
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin
            failures++; $display("FAIL midrst_ctrl busy=%b done=%b exp=0,0", busy, done);
        end
        checks++; if (sum !== 8'h00 || cout !== 1'b0) begin
            failures++; $display("FAIL midrst_result got=%h/%b exp=00/0", sum, cout);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) cnt++;
        end
        checks++; if (cnt !== 0) begin failures++; $display("FAIL midrst_activity got=%0d exp=0", cnt); end
        run_op(8'h0F, 8'h01, 1'b0, lat);
        checks++; if (lat !== 5 || sum !== 8'h10 || cout !== 1'b0) begin
            failures++; $display("FAIL midrst_next got=lat%0d %h/%b exp=lat5 10/0", lat, sum, cout);
        end
        @(negedge clk);
    endtask

    task automatic test_width2();
        a2 = 2'd3; b2 = 2'd3; cin2 = 1'b1; start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        checks++; if (busy2 !== 1'b1 || done2 !== 1'b0) begin
            failures++; $display("FAIL w2_run busy=%b done=%b exp=1,0", busy2, done2);
        end
        checks++; if (slice_a2 !== 2'd3 || slice_b2 !== 2'd3 || slice_ci2 !== 1'b1) begin
            failures++; $display("FAIL w2_slice got=(%0d,%0d,%0d) exp=(3,3,1)", slice_a2, slice_b2, slice_ci2);
        end
        @(negedge clk);
        checks++; if (done2 !== 1'b1 || busy2 !== 1'b0) begin
            failures++; $display("FAIL w2_done done=%b busy=%b exp=1,0", done2, busy2);
        end
        checks++; if (sum2 !== 2'd3 || cout2 !== 1'b1) begin
            failures++; $display("FAIL w2_result got=%0d/%b exp=3/1", sum2, cout2);
        end
        @(negedge clk);
        checks++; if (done2 !== 1'b0) begin failures++; $display("FAIL w2_idle got=%b exp=0", done2); end
    endtask

`ifdef AD_SEQ_SUB_EN
    task automatic test_sub();
        int lat;
        op_sub = 1'b1;
        run_op(8'h10, 8'h01, 1'b0, lat);
        checks++; if (lat !== 5 || sum !== 8'h0F || cout !== 1'b1) begin
            failures++; $display("FAIL sub0 got=lat%0d %h/%b exp=lat5 0f/1", lat, sum, cout);
        end
        @(negedge clk);
        run_op(8'h01, 8'h02, 1'b1, lat);
        checks++; if (lat !== 5 || sum !== 8'hFF || cout !== 1'b0) begin
            failures++; $display("FAIL sub1 got=lat%0d %h/%b exp=lat5 ff/0", lat, sum, cout);
        end
        op_sub = 1'b0;
        @(negedge clk);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_back_to_back();
        test_ignore_start();
        test_reset_mid_run();
        test_width2();
`ifdef AD_SEQ_SUB_EN
        test_sub();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
